// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer holding DEPTH 8-bit read/write registers
// at addresses 0..DEPTH-1 and a read-only ID register at 8'hFF. WAIT_STATES
// access cycles are inserted before P_ready. All outputs are registered.
// Optional feature macro: APB_SLAVE_REGFILE_SLVERR_EN. When it is defined,
// P_slverr flags unmapped accesses and writes to the ID register. When it is
// undefined, P_slverr is tied to 0.
// Handshake: a transfer is accepted in IDLE on a setup phase
// (P_sel=1, P_enable=0). It completes on the rising edge where
// P_sel & P_enable & P_ready are all 1. Dropping P_sel before that edge
// aborts the transfer, and no write is performed.
module apb_slave_regfile #(
  parameter int         DEPTH       = 16,
  parameter int         WAIT_STATES = 0,
  parameter logic [7:0] ID_VALUE    = 8'hA5
) (
  input  logic       P_clk,
  input  logic       P_reset_n,
  input  logic       P_sel,
  input  logic       P_enable,
  input  logic       P_write,
  input  logic [7:0] P_addr,
  input  logic [7:0] P_wdata,
  output logic [7:0] P_rdata,
  output logic       P_ready,
  output logic       P_slverr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_RW  = 2'd0,
    CLS_RO  = 2'd1,
    CLS_UNM = 2'd2
  } cls_t;

  localparam logic [3:0] WS     = 4'(WAIT_STATES);
  localparam logic [8:0] DEPTH9 = 9'(DEPTH);

  state_t     state;
  state_t     state_nxt;
  cls_t       cls;
  cls_t       cls_now;
  logic [3:0] wait_cnt;
  logic [7:0] regs [DEPTH];
  logic [7:0] rd_src;
  logic       load;
  logic       complete;
  logic       wr_commit;

  // Classify the address currently on the bus.
  always_comb begin
    cls_now = CLS_UNM;
    if ({1'b0, P_addr} < DEPTH9) begin
      cls_now = CLS_RW;
    end else if (P_addr == 8'hFF) begin
      cls_now = CLS_RO;
    end
  end

  // Read data source: register file, ID constant, or zero for unmapped space.
  always_comb begin
    rd_src = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (P_addr == 8'(i)) begin
        rd_src = regs[i];
      end
    end
    if (P_addr == 8'hFF) begin
      rd_src = ID_VALUE;
    end
  end

  // State register.
  always_ff @(posedge P_clk) begin
    if (!P_reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. P_enable without a setup phase is ignored in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (P_sel && !P_enable) begin
          state_nxt = (WS == 4'd0) ? S_READY : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!P_sel) begin
          state_nxt = S_IDLE;
        end else if (P_enable && wait_cnt == 4'd1) begin
          state_nxt = S_READY;
        end
      end
      S_READY: begin
        if (!P_sel || (P_enable && P_ready)) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Response data is captured on the edge that enters READY.
  // A write is committed only when a legal RW transfer completes.
  assign load      = (state_nxt == S_READY) && (state != S_READY);
  assign complete  = (state == S_READY) && P_sel && P_enable && P_ready;
  assign wr_commit = complete && P_write && (cls == CLS_RW);

  // Registered outputs, wait counter, latched address class and register file.
  always_ff @(posedge P_clk) begin
    if (!P_reset_n) begin
      P_ready  <= 1'b0;
      P_rdata  <= 8'h00;
      wait_cnt <= 4'd0;
      cls      <= CLS_UNM;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      if (state == S_IDLE && P_sel && !P_enable) begin
        cls      <= cls_now;
        wait_cnt <= WS;
      end else if (state == S_WAIT && P_sel && P_enable) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (load) begin
        P_ready <= 1'b1;
        P_rdata <= rd_src;
      end else if (state != S_IDLE && state_nxt == S_IDLE) begin
        P_ready <= 1'b0;
      end
      if (wr_commit) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (P_addr == 8'(i)) begin
            regs[i] <= P_wdata;
          end
        end
      end
    end
  end

`ifdef APB_SLAVE_REGFILE_SLVERR_EN
  logic err_now;
  logic slverr_q;

  // The error applies to any unmapped access and to any write of the ID register.
  assign err_now = (cls_now == CLS_UNM) || ((cls_now == CLS_RO) && P_write);

  // The error flag follows the same load and clear timing as P_ready.
  always_ff @(posedge P_clk) begin
    if (!P_reset_n) begin
      slverr_q <= 1'b0;
    end else if (load) begin
      slverr_q <= err_now;
    end else if (state != S_IDLE && state_nxt == S_IDLE) begin
      slverr_q <= 1'b0;
    end
  end

  assign P_slverr = slverr_q;
`else
  assign P_slverr = 1'b0;
`endif

endmodule
